taitosj_pf_shifter: RTL and testbench

Three-layer playfield pixel serializer sitting directly downstream of the sync bus. Each layer owns a staging register filled by the tile fetch sequencer (three 8-bit bitplanes plus a 3-bit colour attribute) and a parallel-in shifter. The shifter loads from staging when the sync bus asserts that layer's fine-scroll load strobe (SN1LD/SN2LD/SN3LD low). It then emits one 3bpp pixel per clock, with its colour, toward the priority/palette stage.

---
 rtl/taitosj_pf_shifter.sv | 170 +++++++++++++++++
 tb/tb_taitosj_pf_shifter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/taitosj_pf_shifter.sv
// Three-layer playfield serializer: per-layer staging registers feed 8-bit parallel-in shifters.
// Optional macro TAITOSJ_PF_UNDERRUN_EN: zero-fill on empty load plus sticky UNDERRUN flags.
module taitosj_pf_shifter (
  input  logic       clkm_6MHZ,
  input  logic       RESET_n,
  input  logic       HINV,
  input  logic       BLANK,
  input  logic       SN1LD,
  input  logic       SN2LD,
  input  logic       SN3LD,
  input  logic       ST_WE,
  input  logic [1:0] ST_LAYER,
  input  logic [1:0] ST_PLANE,
  input  logic [7:0] ST_D,
  input  logic       UNDER_CLR,
  output logic [5:0] PF1_PIX,
  output logic [5:0] PF2_PIX,
  output logic [5:0] PF3_PIX,
  output logic [2:0] PF_OPAQUE,
  output logic [2:0] UNDERRUN,
  output logic [2:0] ST_FULL
);

  logic [2:0] ld_n;
  logic [2:0] full_w;
  logic [2:0] under_w;
  logic [2:0] opaque_w;
  logic [5:0] pix_w [3];

  assign ld_n = {SN3LD, SN2LD, SN1LD};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_layer
      logic [7:0] stg_p0_q, stg_p1_q, stg_p2_q;
      logic [7:0] stg_p0_d, stg_p1_d, stg_p2_d;
      logic [2:0] stg_col_q, stg_col_d;
      logic       full_q, full_d;
      logic [7:0] sh_p0_q, sh_p1_q, sh_p2_q;
      logic [7:0] sh_p0_d, sh_p1_d, sh_p2_d;
      logic [2:0] sh_col_q, sh_col_d;
      logic       under_q, under_d;
      logic       wr_sel;
      logic       load;
      logic       take;
      logic [2:0] pix;

      assign wr_sel = ST_WE && (ST_LAYER == 2'(gi));
      assign load   = ~ld_n[gi];

`ifdef TAITOSJ_PF_UNDERRUN_EN
      assign take = full_q;
`else
      // Empty loads still copy staging, so the previous tile repeats.
      assign take = 1'b1;
`endif

      // Staging side: the fetch sequencer writes plane 2 last, which marks the tile ready.
      always_comb begin
        stg_p0_d  = stg_p0_q;
        stg_p1_d  = stg_p1_q;
        stg_p2_d  = stg_p2_q;
        stg_col_d = stg_col_q;
        full_d    = full_q;
        if (load) begin
          full_d = 1'b0;
        end
        if (wr_sel) begin
          case (ST_PLANE)
            2'd0: stg_p0_d = ST_D;
            2'd1: stg_p1_d = ST_D;
            2'd2: begin
              stg_p2_d = ST_D;
              full_d   = 1'b1;
            end
            default: stg_col_d = ST_D[2:0];
          endcase
        end
      end

      // Shifter side: loads always see the pre-edge staging contents.
      always_comb begin
        sh_p0_d  = sh_p0_q;
        sh_p1_d  = sh_p1_q;
        sh_p2_d  = sh_p2_q;
        sh_col_d = sh_col_q;
        if (load) begin
          if (take) begin
            sh_p0_d  = stg_p0_q;
            sh_p1_d  = stg_p1_q;
            sh_p2_d  = stg_p2_q;
            sh_col_d = stg_col_q;
          end else begin
            sh_p0_d = 8'h00;
            sh_p1_d = 8'h00;
            sh_p2_d = 8'h00;
          end
        end else if (HINV) begin
          sh_p0_d = {1'b0, sh_p0_q[7:1]};
          sh_p1_d = {1'b0, sh_p1_q[7:1]};
          sh_p2_d = {1'b0, sh_p2_q[7:1]};
        end else begin
          sh_p0_d = {sh_p0_q[6:0], 1'b0};
          sh_p1_d = {sh_p1_q[6:0], 1'b0};
          sh_p2_d = {sh_p2_q[6:0], 1'b0};
        end
      end

`ifdef TAITOSJ_PF_UNDERRUN_EN
      // A fresh underrun outranks a simultaneous clear.
      always_comb begin
        under_d = under_q;
        if (UNDER_CLR) begin
          under_d = 1'b0;
        end
        if (load && !full_q) begin
          under_d = 1'b1;
        end
      end
`else
      logic unused_clr;
      assign unused_clr = UNDER_CLR;
      assign under_d    = 1'b0;
`endif

      always_ff @(posedge clkm_6MHZ) begin
        if (!RESET_n) begin
          stg_p0_q  <= 8'h00;
          stg_p1_q  <= 8'h00;
          stg_p2_q  <= 8'h00;
          stg_col_q <= 3'd0;
          full_q    <= 1'b0;
          sh_p0_q   <= 8'h00;
          sh_p1_q   <= 8'h00;
          sh_p2_q   <= 8'h00;
          sh_col_q  <= 3'd0;
          under_q   <= 1'b0;
        end else begin
          stg_p0_q  <= stg_p0_d;
          stg_p1_q  <= stg_p1_d;
          stg_p2_q  <= stg_p2_d;
          stg_col_q <= stg_col_d;
          full_q    <= full_d;
          sh_p0_q   <= sh_p0_d;
          sh_p1_q   <= sh_p1_d;
          sh_p2_q   <= sh_p2_d;
          sh_col_q  <= sh_col_d;
          under_q   <= under_d;
        end
      end

      // Output tap follows HINV immediately; shifter contents are never re-ordered.
      assign pix = HINV ? {sh_p2_q[0], sh_p1_q[0], sh_p0_q[0]}
                        : {sh_p2_q[7], sh_p1_q[7], sh_p0_q[7]};

      assign pix_w[gi]    = BLANK ? 6'd0 : {sh_col_q, pix};
      assign opaque_w[gi] = !BLANK && (pix != 3'd0);
      assign full_w[gi]   = full_q;
      assign under_w[gi]  = under_q;
    end
  endgenerate

  assign PF1_PIX   = pix_w[0];
  assign PF2_PIX   = pix_w[1];
  assign PF3_PIX   = pix_w[2];
  assign PF_OPAQUE = opaque_w;
  assign ST_FULL   = full_w;
  assign UNDERRUN  = under_w;

endmodule

// File: tb/tb_taitosj_pf_shifter.sv
// Self-checking bench for taitosj_pf_shifter; expected pixel streams are queued from tile data.
module tb_taitosj_pf_shifter;

  logic       clk = 1'b0;
  logic       RESET_n, HINV, BLANK, SN1LD, SN2LD, SN3LD, ST_WE, UNDER_CLR;
  logic [1:0] ST_LAYER, ST_PLANE;
  logic [7:0] ST_D;
  logic [5:0] PF1_PIX, PF2_PIX, PF3_PIX;
  logic [2:0] PF_OPAQUE, UNDERRUN, ST_FULL;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb_q[$];

  always #5 clk = ~clk;

  taitosj_pf_shifter dut (
    .clkm_6MHZ(clk), .RESET_n(RESET_n), .HINV(HINV), .BLANK(BLANK),
    .SN1LD(SN1LD), .SN2LD(SN2LD), .SN3LD(SN3LD), .ST_WE(ST_WE),
    .ST_LAYER(ST_LAYER), .ST_PLANE(ST_PLANE), .ST_D(ST_D), .UNDER_CLR(UNDER_CLR),
    .PF1_PIX(PF1_PIX), .PF2_PIX(PF2_PIX), .PF3_PIX(PF3_PIX),
    .PF_OPAQUE(PF_OPAQUE), .UNDERRUN(UNDERRUN), .ST_FULL(ST_FULL)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {colour, pixel} stream for one tile: 8 pixels, then one empty pixel.
  function automatic void expect_tile(input logic [7:0] p0, input logic [7:0] p1,
                                      input logic [7:0] p2, input logic [2:0] col,
                                      input logic hinv);
    for (int k = 0; k < 8; k++) begin
      int b;
      b = hinv ? k : 7 - k;
      sb_q.push_back({col, p2[b], p1[b], p0[b]});
    end
    sb_q.push_back({col, 3'b000});
  endfunction

  task automatic stage_write(input logic [1:0] l, input logic [1:0] plane, input logic [7:0] d);
    ST_WE = 1'b1; ST_LAYER = l; ST_PLANE = plane; ST_D = d;
    tick();
    ST_WE = 1'b0;
  endtask

  task automatic write_tile(input logic [1:0] l, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [2:0] col);
    stage_write(l, 2'd3, {5'd0, col});
    stage_write(l, 2'd0, p0);
    stage_write(l, 2'd1, p1);
    stage_write(l, 2'd2, p2);
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      HINV = 1'($urandom); BLANK = 1'($urandom); SN1LD = 1'($urandom);
      SN2LD = 1'($urandom); SN3LD = 1'($urandom); ST_WE = 1'($urandom);
      ST_LAYER = 2'($urandom); ST_PLANE = 2'($urandom); ST_D = 8'($urandom);
      UNDER_CLR = 1'($urandom);
      tick();
    end
    checks++;
    if ({PF1_PIX, PF2_PIX, PF3_PIX} !== 18'd0) begin
      errors++;
      $display("FAIL reset_pix: got %h %h %h expected 00 00 00", PF1_PIX, PF2_PIX, PF3_PIX);
    end
    checks++;
    if (ST_FULL !== 3'b000 || UNDERRUN !== 3'b000 || PF_OPAQUE !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got full=%b under=%b opaque=%b expected 000 000 000",
               ST_FULL, UNDERRUN, PF_OPAQUE);
    end
    RESET_n = 1'b1; HINV = 1'b0; BLANK = 1'b0; SN1LD = 1'b1; SN2LD = 1'b1; SN3LD = 1'b1;
    ST_WE = 1'b0; ST_LAYER = 2'd0; ST_PLANE = 2'd0; ST_D = 8'h00; UNDER_CLR = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_layer1(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                             input logic [2:0] col, input logic hinv, input string tag);
    write_tile(2'd0, p0, p1, p2, col);
    checks++;
    if (ST_FULL[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s_full_before: got %b expected 1", tag, ST_FULL[0]);
    end
    HINV = hinv;
    expect_tile(p0, p1, p2, col, hinv);
    SN1LD = 1'b0;
    tick();
    SN1LD = 1'b1;
    checks++;
    if (ST_FULL[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s_full_after: got %b expected 0", tag, ST_FULL[0]);
    end
    for (int k = 0; sb_q.size() > 0; k++) begin
      logic [5:0] exp;
      exp = sb_q.pop_front();
      checks++;
      if (PF1_PIX !== exp || PF_OPAQUE[0] !== (exp[2:0] != 3'd0)) begin
        errors++;
        $display("FAIL %s_pix[%0d]: got %h opaque=%b expected %h", tag, k, PF1_PIX,
                 PF_OPAQUE[0], exp);
      end
      tick();
    end
    HINV = 1'b0;
    $display("%s: p0=%h p1=%h p2=%h col=%0d hinv=%b checked", tag, p0, p1, p2, col, hinv);
  endtask

  task automatic test_underrun();
    SN2LD = 1'b0;
    tick();
    SN2LD = 1'b1;
    checks++;
    if (PF2_PIX !== 6'd0) begin
      errors++;
      $display("FAIL under_pix: got %h expected 00", PF2_PIX);
    end
    checks++;
`ifdef TAITOSJ_PF_UNDERRUN_EN
    if (UNDERRUN !== 3'b010) begin
      errors++;
      $display("FAIL under_set: got %b expected 010", UNDERRUN);
    end
    // Clear and a new underrun on the same edge: the flag stays set.
    UNDER_CLR = 1'b1; SN2LD = 1'b0;
    tick();
    SN2LD = 1'b1; UNDER_CLR = 1'b0;
    checks++;
    if (UNDERRUN !== 3'b010) begin
      errors++;
      $display("FAIL under_setwins: got %b expected 010", UNDERRUN);
    end
`else
    if (UNDERRUN !== 3'b000) begin
      errors++;
      $display("FAIL under_tied: got %b expected 000", UNDERRUN);
    end
`endif
    UNDER_CLR = 1'b1;
    tick();
    UNDER_CLR = 1'b0;
    checks++;
    if (UNDERRUN !== 3'b000) begin
      errors++;
      $display("FAIL under_clr: got %b expected 000", UNDERRUN);
    end
    $display("underrun: layer 2 empty load checked");
  endtask

  task automatic test_coincident();
    write_tile(2'd2, 8'hF0, 8'h00, 8'h00, 3'd3);
    expect_tile(8'hF0, 8'h00, 8'h00, 3'd3, 1'b0);
    ST_WE = 1'b1; ST_LAYER = 2'd2; ST_PLANE = 2'd2; ST_D = 8'h80; SN3LD = 1'b0;
    tick();
    ST_WE = 1'b0; SN3LD = 1'b1;
    checks++;
    if (ST_FULL[2] !== 1'b1) begin
      errors++;
      $display("FAIL coin_full: got %b expected 1", ST_FULL[2]);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; sb_q.size() > 0; k++) begin
        logic [5:0] exp;
        exp = sb_q.pop_front();
        checks++;
        if (PF3_PIX !== exp) begin
          errors++;
          $display("FAIL coin%0d_pix[%0d]: got %h expected %h", pass, k, PF3_PIX, exp);
        end
        tick();
      end
      if (pass == 0) begin
        expect_tile(8'hF0, 8'h00, 8'h80, 3'd3, 1'b0);
        SN3LD = 1'b0;
        tick();
        SN3LD = 1'b1;
        checks++;
        if (ST_FULL[2] !== 1'b0) begin
          errors++;
          $display("FAIL coin_full_after: got %b expected 0", ST_FULL[2]);
        end
      end
    end
    $display("coincident: layer 3 write+load checked");
  endtask

  task automatic test_blank();
    write_tile(2'd0, 8'hA5, 8'hFF, 8'h00, 3'd5);
    expect_tile(8'hA5, 8'hFF, 8'h00, 3'd5, 1'b0);
    SN1LD = 1'b0;
    tick();
    SN1LD = 1'b1;
    begin
      logic [5:0] exp;
      exp = sb_q.pop_front();
      checks++;
      if (PF1_PIX !== exp) begin
        errors++;
        $display("FAIL blank_first: got %h expected %h", PF1_PIX, exp);
      end
    end
    BLANK = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (PF1_PIX !== 6'd0 || PF_OPAQUE !== 3'b000) begin
        errors++;
        $display("FAIL blank_hold[%0d]: got %h opaque=%b expected 00 000", j, PF1_PIX, PF_OPAQUE);
      end
    end
    void'(sb_q.pop_front());
    void'(sb_q.pop_front());
    BLANK = 1'b0;
    #1;
    for (int k = 4; sb_q.size() > 0; k--) begin
      logic [5:0] exp;
      exp = sb_q.pop_front();
      checks++;
      if (PF1_PIX !== exp) begin
        errors++;
        $display("FAIL blank_resume[bit%0d]: got %h expected %h", k, PF1_PIX, exp);
      end
      tick();
    end
    $display("blank: 3-edge blank mid-tile checked");
  endtask

  task automatic test_ignored_layer();
    stage_write(2'd3, 2'd2, 8'hFF);
    checks++;
    if (ST_FULL !== 3'b000) begin
      errors++;
      $display("FAIL ignored_layer: got full=%b expected 000", ST_FULL);
    end
    $display("ignored_layer: layer 3 write checked");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_layer1(8'hA5, 8'hFF, 8'h00, 3'd5, 1'b0, "l1_msb");
    test_layer1(8'hA5, 8'hFF, 8'h00, 3'd5, 1'b1, "l1_lsb");
    test_layer1(8'h01, 8'hFF, 8'h00, 3'd5, 1'b1, "l1_lsb01");
    test_underrun();
    test_coincident();
    test_blank();
    test_ignored_layer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
